echo_detector: RTL and testbench

Sits between the receive beamformer and time_of_flight. Converts the aggregated offset-binary waveform into a smoothed envelope, holds detection off for a blanking window after each burst so transmit ringing is ignored, and applies hysteresis thresholds. Emits one qualified echo event per burst, carrying the emission-relative timestamp of the first threshold crossing and the peak envelope value.

---
 rtl/echo_detector_if.sv | 26 ++
 rtl/echo_detector.sv | 145 ++++++++++++++
 tb/tb_echo_detector.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/echo_detector_if.sv
// Sample/echo bus between the beamformer side and echo_detector.
// The master drives the waveform and burst strobe; the detector (slave) returns the echo results.
interface echo_detector_if #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int TIME_WIDTH   = 24
);
  logic                    burst_start_in;
  logic [TIME_WIDTH-1:0]   time_in;
  logic [SAMPLE_WIDTH-1:0] sample_in;
  logic                    sample_valid_in;
  logic                    echo_valid_out;
  logic [TIME_WIDTH-1:0]   echo_time_out;
  logic [SAMPLE_WIDTH-1:0] echo_peak_out;
  logic [SAMPLE_WIDTH-1:0] envelope_out;
  logic                    armed_out;

  modport master (
    output burst_start_in, time_in, sample_in, sample_valid_in,
    input  echo_valid_out, echo_time_out, echo_peak_out, envelope_out, armed_out
  );

  modport slave (
    input  burst_start_in, time_in, sample_in, sample_valid_in,
    output echo_valid_out, echo_time_out, echo_peak_out, envelope_out, armed_out
  );
endinterface

// File: rtl/echo_detector.sv
// Envelope (|x - midscale|), moving average, post-burst blanking and hysteresis thresholding;
// reports one echo per burst with the first-crossing timestamp and the peak average.
module echo_detector #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int TIME_WIDTH   = 24,
  parameter int AVG_LOG2     = 3,
  parameter int THRESHOLD_HI = 5000,
  parameter int THRESHOLD_LO = 3000,
  parameter int BLANK_CYCLES = 600000
) (
  input logic           clk_in,
  input logic           rst_in,
  echo_detector_if.slave bus
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = SAMPLE_WIDTH + AVG_LOG2;
  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [SAMPLE_WIDTH-1:0] MID = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [SAMPLE_WIDTH-1:0] HI  = SAMPLE_WIDTH'(THRESHOLD_HI);
  localparam logic [SAMPLE_WIDTH-1:0] LO  = SAMPLE_WIDTH'(THRESHOLD_LO);

  typedef enum logic [2:0] {IDLE, BLANK, ARMED, TRACK, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SAMPLE_WIDTH-1:0] env_abs, env_q;
  logic                    env_valid_q;
  logic [TIME_WIDTH-1:0]   env_time_q;
  logic [SAMPLE_WIDTH-1:0] buf_q [DEPTH];
  logic [SUM_W-1:0]        sum_q;
  logic                    avg_valid_q;
  logic [TIME_WIDTH-1:0]   avg_time_q;
  logic [SAMPLE_WIDTH-1:0] avg, peak_max;
  logic [CNT_W-1:0]        cnt_q;
  logic [TIME_WIDTH-1:0]   crossing_q;
  logic [SAMPLE_WIDTH-1:0] peak_q;
  logic                    echo_valid_q;
  logic [TIME_WIDTH-1:0]   echo_time_q;
  logic [SAMPLE_WIDTH-1:0] echo_peak_q;
  logic                    capture, peak_upd, emit;

  assign env_abs  = (bus.sample_in >= MID) ? bus.sample_in - MID : MID - bus.sample_in;
  assign avg      = sum_q[SUM_W-1:AVG_LOG2];
  assign peak_max = (avg > peak_q) ? avg : peak_q;

  // Averager pipeline: envelope at t+1, running sum / avg_valid at t+2.
  // A burst flushes everything in flight, including a sample valid in the same cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in || bus.burst_start_in) begin
      env_q       <= '0;
      env_valid_q <= 1'b0;
      env_time_q  <= '0;
      sum_q       <= '0;
      avg_valid_q <= 1'b0;
      avg_time_q  <= '0;
      // NOTE: the window buffer is cleared explicitly because a burst must flush old history
      // from the running sum; it therefore lives in flops rather than a RAM.
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      env_valid_q <= bus.sample_valid_in;
      if (bus.sample_valid_in) begin
        env_q      <= env_abs;
        env_time_q <= bus.time_in;
      end
      avg_valid_q <= env_valid_q;
      if (env_valid_q) begin
        buf_q[0] <= env_q;
        for (int i = 1; i < DEPTH; i++) buf_q[i] <= buf_q[i-1];
        sum_q      <= sum_q + SUM_W'(env_q) - SUM_W'(buf_q[DEPTH-1]);
        avg_time_q <= env_time_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = state_q;
    capture  = 1'b0;
    peak_upd = 1'b0;
    emit     = 1'b0;
    case (state_q)
      IDLE:  ;
      BLANK: if (cnt_q == BLANK_LAST) state_d = ARMED;
      ARMED: if (avg_valid_q && avg > HI) begin
               capture = 1'b1;
               state_d = TRACK;
             end
      TRACK: if (avg_valid_q) begin
               peak_upd = 1'b1;
               if (avg < LO) begin
                 emit    = 1'b1;
                 state_d = DONE;
               end
             end
      DONE:  ;
      default: state_d = IDLE;
    endcase
    // A new burst overrides everything and silently drops an echo in progress.
    if (bus.burst_start_in) begin
      capture  = 1'b0;
      peak_upd = 1'b0;
      emit     = 1'b0;
      state_d  = (BLANK_CYCLES == 0) ? ARMED : BLANK;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q        <= '0;
      crossing_q   <= '0;
      peak_q       <= '0;
      echo_valid_q <= 1'b0;
      echo_time_q  <= '0;
      echo_peak_q  <= '0;
    end else begin
      echo_valid_q <= emit;
      if (bus.burst_start_in)   cnt_q <= '0;
      else if (state_q == BLANK) cnt_q <= cnt_q + 1'b1;
      if (capture) begin
        crossing_q <= avg_time_q;
        peak_q     <= avg;
      end else if (peak_upd) begin
        peak_q <= peak_max;
      end
      if (emit) begin
        echo_time_q <= crossing_q;
        echo_peak_q <= peak_max;
      end
    end
  end

  assign bus.echo_valid_out = echo_valid_q;
  assign bus.echo_time_out  = echo_time_q;
  assign bus.echo_peak_out  = echo_peak_q;
  assign bus.envelope_out   = avg;
  assign bus.armed_out      = (state_q == ARMED);

endmodule

// File: tb/tb_echo_detector.sv
// Directed bench for echo_detector: expected envelopes and echoes are queued when stimulus
// is driven and compared by a monitor on the falling edge when they fall due.
module tb_echo_detector;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct { int due; logic [15:0] env; } env_exp_t;
  typedef struct { int due; logic [23:0] tim; logic [15:0] peak; } echo_exp_t;

  env_exp_t  env_q [$];
  echo_exp_t echo_q [$];
  env_exp_t  env_item;
  echo_exp_t echo_item;

  localparam logic [15:0] EXC_ENV [8] = '{16'd2000, 16'd4000, 16'd6000, 16'd8000,
                                          16'd6000, 16'd4000, 16'd2000, 16'd0};

  echo_detector_if #(.SAMPLE_WIDTH(16), .TIME_WIDTH(24)) bus ();

  echo_detector #(
    .SAMPLE_WIDTH(16), .TIME_WIDTH(24), .AVG_LOG2(2),
    .THRESHOLD_HI(5000), .THRESHOLD_LO(3000), .BLANK_CYCLES(10)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (env_q.size() > 0 && env_q[0].due == cyc) begin
      env_item = env_q.pop_front();
      check("envelope", 32'(bus.envelope_out), 32'(env_item.env));
    end
    if (bus.echo_valid_out === 1'b1) begin
      if (echo_q.size() == 0) begin
        check("spurious_echo", 32'(bus.echo_valid_out), 32'd0);
      end else begin
        echo_item = echo_q.pop_front();
        check("echo_cycle", cyc, echo_item.due);
        check("echo_time", 32'(bus.echo_time_out), 32'(echo_item.tim));
        check("echo_peak", 32'(bus.echo_peak_out), 32'(echo_item.peak));
      end
    end else if (echo_q.size() > 0 && echo_q[0].due < cyc) begin
      echo_item = echo_q.pop_front();
      check("echo_missing", 32'(bus.echo_valid_out), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.sample_valid_in = 1'b0;
    repeat (n) step();
  endtask

  task automatic drive_sample(input logic [15:0] s, input logic [23:0] t,
                              input logic [15:0] exp_env, input bit chk);
    bus.sample_in       = s;
    bus.time_in         = t;
    bus.sample_valid_in = 1'b1;
    if (chk) env_q.push_back('{due: cyc + 2, env: exp_env});
    step();
    bus.sample_valid_in = 1'b0;
  endtask

  task automatic push_echo(input logic [23:0] t, input logic [15:0] p);
    echo_q.push_back('{due: cyc + 3, tim: t, peak: p});
  endtask

  // Burst with no samples during blanking, then confirm ARMED is reached on time.
  task automatic arm();
    bus.sample_valid_in = 1'b0;
    bus.burst_start_in  = 1'b1;
    step();
    bus.burst_start_in  = 1'b0;
    idle(9);
    check("armed_early", 32'(bus.armed_out), 32'd0);
    idle(1);
    check("armed_rise", 32'(bus.armed_out), 32'd1);
  endtask

  // Four full-scale-8000 samples then four midscale samples.
  task automatic excursion(input logic [15:0] s, input logic [23:0] base, input bit expect_echo);
    for (int i = 0; i < 8; i++) begin
      if (i == 6 && expect_echo) push_echo(base + 24'd2, 16'd8000);
      drive_sample((i < 4) ? s : 16'd32768, base + 24'(i), EXC_ENV[i], 1'b1);
    end
    idle(5);
    check("not_armed_after", 32'(bus.armed_out), 32'd0);
  endtask

  initial begin
    int k;
    rst                 = 1'b1;
    bus.burst_start_in  = 1'b0;
    bus.sample_in       = 16'd32768;
    bus.time_in         = '0;
    bus.sample_valid_in = 1'b0;

    // Reset with random inputs
    for (int r = 0; r < 2; r++) begin
      bus.burst_start_in  = 1'($urandom);
      bus.sample_valid_in = 1'($urandom);
      bus.sample_in       = 16'($urandom);
      bus.time_in         = 24'($urandom);
      step();
      check("rst_echo_valid", 32'(bus.echo_valid_out), 32'd0);
      check("rst_echo_time", 32'(bus.echo_time_out), 32'd0);
      check("rst_echo_peak", 32'(bus.echo_peak_out), 32'd0);
      check("rst_envelope", 32'(bus.envelope_out), 32'd0);
      check("rst_armed", 32'(bus.armed_out), 32'd0);
    end
    rst = 1'b0;
    bus.burst_start_in = 1'b0;
    for (int r = 0; r < 6; r++) begin
      bus.sample_valid_in = 1'($urandom);
      bus.sample_in       = 16'($urandom);
      step();
      check("idle_not_armed", 32'(bus.armed_out), 32'd0);
    end
    idle(2);

    // Blanking with envelope 10000 fed every cycle
    k = cyc;
    bus.burst_start_in = 1'b1;
    step();
    bus.burst_start_in = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      check("blank_armed", 32'(bus.armed_out), 32'(cyc == k + 11));
      drive_sample(16'd42768, 24'(i), (i >= 4) ? 16'd10000 : 16'(2500 * i), 1'b1);
    end
    idle(3);

    // Positive- and negative-going basic echoes
    arm();
    excursion(16'd40768, 24'd100, 1'b1);
    arm();
    excursion(16'd24768, 24'd100, 1'b1);

    // Hysteresis: average parked at 4000 stays in TRACK, then a drop resolves it
    arm();
    for (int i = 0; i < 4; i++)
      drive_sample(16'd24768, 24'(200 + i), EXC_ENV[i], 1'b1);
    drive_sample(16'd32768, 24'd204, 16'd6000, 1'b1);
    drive_sample(16'd32768, 24'd205, 16'd4000, 1'b1);
    for (int i = 0; i < 8; i++)
      drive_sample(((i % 4) < 2) ? 16'd24768 : 16'd32768, 24'(206 + i), 16'd4000, 1'b1);
    check("hold_not_armed", 32'(bus.armed_out), 32'd0);
    push_echo(24'd202, 16'd8000);
    drive_sample(16'd32768, 24'd214, 16'd2000, 1'b1);
    idle(6);

    // Burst mid-echo together with a valid sample
    arm();
    for (int i = 0; i < 4; i++)
      drive_sample(16'd40768, 24'(300 + i), EXC_ENV[i], 1'b1);
    idle(2);
    check("track_not_armed", 32'(bus.armed_out), 32'd0);
    k = cyc;
    bus.burst_start_in  = 1'b1;
    bus.sample_valid_in = 1'b1;
    bus.sample_in       = 16'd40768;
    bus.time_in         = 24'd399;
    step();
    bus.burst_start_in  = 1'b0;
    bus.sample_valid_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      check("drop_envelope", 32'(bus.envelope_out), 32'd0);
      check("drop_armed", 32'(bus.armed_out), 32'(cyc >= k + 11));
      step();
    end

    // One echo per burst, then a fresh echo after the next burst
    excursion(16'd40768, 24'd400, 1'b1);
    excursion(16'd40768, 24'd500, 1'b0);
    arm();
    excursion(16'd24768, 24'd600, 1'b1);

    idle(10);
    check("echo_queue_drained", 32'(echo_q.size()), 32'd0);
    check("env_queue_drained", 32'(env_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
